// File: rtl/_demux4_reg.sv
// ============================================================================
//  Module      : _demux4_reg
//  Description : Registered 1-to-4 demultiplexer. One word per cycle on a
//                valid/ready input is steered by a 2-bit select into one of
//                four single-entry output slots, each with its own
//                valid/ready handshake. Output data comes only from registers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module _demux4_reg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_sel,
    input  logic [N-1:0] in_data,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [N-1:0] out0_data,
    output logic [N-1:0] out1_data,
    output logic [N-1:0] out2_data,
    output logic [N-1:0] out3_data,
    output logic [3:0]   pending
);

    logic [3:0]   r_valid;
    logic [N-1:0] r_data [4];
    logic         w_in_ready;
    logic         w_in_xfer;

    // The selected slot can take a word if it is empty or draining this cycle;
    // in_valid is deliberately not part of this term.
    always_comb begin
        w_in_ready = ~rst & (~r_valid[in_sel] | out_ready[in_sel]);
        w_in_xfer  = in_valid & w_in_ready;
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_ch
            // Per-channel slot: a fill wins over a drain so a draining slot
            // is refilled on the same edge without a bubble.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[g] <= 1'b0;
                    r_data[g]  <= '0;
                end else if (w_in_xfer && (in_sel == 2'(g))) begin
                    r_valid[g] <= 1'b1;
                    r_data[g]  <= in_data;
                end else if (r_valid[g] && out_ready[g]) begin
                    r_valid[g] <= 1'b0;
                end
            end
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign pending   = r_valid;
    assign out0_data = r_data[0];
    assign out1_data = r_data[1];
    assign out2_data = r_data[2];
    assign out3_data = r_data[3];

endmodule

`default_nettype wire

// File: doc/_demux4_reg.md
Name: _demux4_reg

Overview:
- Registered 4-output demultiplexer: the fan-out counterpart of the 4-input word mux.
- Accepts one word per cycle on a valid/ready input and steers it by a 2-bit select to one of four output channels.
- Each output channel has a one-entry holding register and its own valid/ready handshake.
- Used to dispatch datapath results (ALU/memory/writeback) to independent consumers without combinational paths from input data to output data.

Parameters:
n, constants::WORD_LENGTH, width in bits of the data word

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input word present
in_ready  output  1  block can accept the input word this cycle
in_sel  input  2  destination channel index (0..3) for the input word
in_data  input  n  input word
out_valid  output  4  bit X: channel X holds a word
out_ready  input  4  bit X: consumer X takes the channel X word this cycle
out0_data  output  n  channel 0 word
out1_data  output  n  channel 1 word
out2_data  output  n  channel 2 word
out3_data  output  n  channel 3 word
pending  output  4  mirror of out_valid for status/stall logic

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid & in_ready at a rising edge.
  - Output transfer on channel X occurs when out_valid[X] & out_ready[X] at a rising edge.
- Reset:
  - rst=1 at an edge clears out_valid and pending to 4'b0000 and all outX_data to 0.
  - While rst=1, in_ready=0.
  - A word held when rst is asserted is discarded; there is no partial completion.
- Ready rule:
  - in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]).
  - in_ready is combinational from in_sel, out_valid and out_ready only; it never depends on in_valid.
- Channel X register update, per edge, rst=0, in priority order:
  - Input transfer with in_sel=X: outX_data <= in_data, out_valid[X] <= 1. This includes the case where channel X drains in the same cycle, so a full slot with out_ready[X]=1 is refilled with no bubble.
  - Otherwise, output transfer on X: out_valid[X] <= 0. outX_data holds its old value, which is don't-care while invalid.
  - Otherwise: hold.
- Latency: a word accepted at edge k is visible on outX_data with out_valid[X]=1 after edge k, i.e. 1 cycle.
- Throughput: 1 word/cycle to any channel whose consumer keeps out_ready high.
- Independence:
  - A full, stalled channel blocks only input words selecting that channel.
  - Channels never reorder their own words.
  - There is no ordering guarantee between different channels.
- Stability:
  - While out_valid[X]=1 and out_ready[X]=0, outX_data must remain constant.
  - A held word is never overwritten, because in_ready=0 for that selection.
- Data masking: outX_data is not masked by out_valid; consumers must qualify with out_valid.
- Input changes without a transfer: in_sel or in_data changing while in_valid=1 and in_ready=0 is permitted; whatever is present at the accepting edge is captured.
- in_valid=0: no state change from the input side, regardless of in_sel.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> in_ready=0 throughout; after release out_valid=0000, outX_data=0, pending=0000.
- Basic routing: with out_ready=1111, send words 0xA0, 0xA1, 0xA2, 0xA3 on sel 0, 1, 2, 3 in consecutive cycles -> each appears on the matching outX_data one cycle later with only that out_valid bit set for that cycle, and in_ready=1 throughout.
- Backpressure: out_ready=0000, send 0x11 to ch2, then 0x22 to ch2 -> 0x11 held stable on out2_data and in_ready=0 on the second word. Raise out_ready[2] for one cycle -> 0x11 consumed and 0x22 captured on the same edge; out_valid[2] stays 1 with out2_data=0x22.
- Channel independence: ch1 full with out_ready[1]=0, then stream sel=3 words 0x30..0x33 -> all accepted back-to-back on ch3; ch1 word unchanged; in_ready drops only when sel=1 is presented.
- Mid-operation reset: fill all four channels, then assert rst for 1 cycle -> out_valid=0000 next cycle; the held words are never seen as valid again.
- Random: randomized in_valid, in_sel and out_ready for 10k cycles against a per-channel queue model -> no loss, duplication or reordering per channel, and data stable while stalled.
